id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline stage between the register file / decode (ID) and the ALU (EX) of the 5-stage MIPS core.
- Captures register read data, decoded control bits and instruction fields into the ID/EX register.
- Sign- or zero-extends the immediate and selects the destination register.
- Bypasses same-cycle writeback into read data, detects load-use hazards (stalls upstream, inserts bubbles), honours downstream stall and branch flush.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, width of saturating bubble counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  branch taken/redirect; squash ID/EX contents
stall_in  in  1  downstream (EX/MEM) busy; hold ID/EX register
id_valid  in  1  ID slot holds a real instruction
id_instr  in  32  instruction word in ID
id_pc_plus4  in  32  PC+4 of ID instruction
id_rd_data1  in  DATA_WIDTH  register file data for rs
id_rd_data2  in  DATA_WIDTH  register file data for rt
id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded controls
id_alu_op  in  2  ALU op class
wb_reg_write  in  1  writeback enable this cycle
wb_write_reg  in  REG_ADDR_WIDTH  writeback destination
wb_data  in  DATA_WIDTH  writeback value
hazard_stall  out  1  combinational; freeze PC and IF/ID
ex_valid  out  1  EX slot valid
ex_pc_plus4  out  32  registered PC+4
ex_rs_data, ex_rt_data  out  DATA_WIDTH each  registered (bypassed) operands
ex_imm  out  DATA_WIDTH  extended immediate
ex_rs, ex_rt, ex_write_reg  out  REG_ADDR_WIDTH each  source indices / selected destination
ex_shamt  out  5  instr[10:6]
ex_funct  out  6  instr[5:0]
ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_branch, ex_alu_src  out  1 each  registered controls
ex_alu_op  out  2  registered ALU op
bubble_count  out  CNT_WIDTH  saturating count of inserted load-use bubbles

Behaviour:
- Field decode: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm16=instr[15:0], opcode=instr[31:26].
- Immediate: zero-extended when opcode is 0x0C (ANDI), 0x0D (ORI) or 0x0E (XORI); sign-extended otherwise.
- Destination: write_reg = id_reg_dst ? rd : rt.
- WB bypass (comb, before capture): if wb_reg_write && wb_write_reg!=0 && wb_write_reg==rs, rs data=wb_data, else id_rd_data1. Same rule for rt/id_rd_data2.
- hazard_stall = id_valid && ex_valid && ex_mem_read && ex_rt!=0 && (ex_rt==rs || ex_rt==rt). Output is forced 0 while flush=1.
- Register update priority each posedge clk, highest first:
  1. rst: all outputs 0, bubble_count 0.
  2. flush: load bubble (ex_valid and all ex_ control bits 0; data fields don't-care, drive 0). Flush overrides stall_in.
  3. stall_in: hold every ex_ register unchanged. No bubble is counted.
  4. hazard_stall: load bubble as in 2. bubble_count increments, saturating at all-ones.
  5. Otherwise load from ID. ex_valid=id_valid. When id_valid=0, all control bits load as 0.
- Latency: one cycle ID→EX.
- A held register (stall_in) keeps its load-use comparison live, so hazard_stall may stay asserted across a stall.
- Every bubble guarantees ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=0. No architectural side effects.
- rst mid-stall or mid-hazard clears everything. hazard_stall is 0 on the cycle after reset.
- Register 0 never matches a hazard or a bypass.

Test Plan:
- Reset: hold rst 2 cycles with junk inputs → all ex_ outputs 0, bubble_count=0, hazard_stall=0.
- Pass-through: ADDI instr 0x2108FFFC (rs=8, rt=8, imm=-4), rd_data1=0x10, reg_dst=0 → next cycle ex_imm=0xFFFFFFFC, ex_write_reg=8, ex_rs_data=0x10, ex_valid=1. ORI 0x3508FFFC → ex_imm=0x0000FFFC.
- WB bypass: ID rs=9, id_rd_data1=0x1, wb_reg_write=1, wb_write_reg=9, wb_data=0xDEADBEEF → ex_rs_data=0xDEADBEEF. Repeat with wb_write_reg=0 → ex_rs_data=0x1.
- Load-use: LW to rt=5 in EX, ID instr ADD with rs=5 → hazard_stall=1 same cycle. Next cycle ex_valid=0, controls 0, bubble_count=1. Following cycle the ADD loads with hazard_stall=0.
- Priority: flush=1 with stall_in=1 → bubble loaded. stall_in=1 alone for 3 cycles → ex_ outputs unchanged, bubble_count unchanged.
- Saturation: CNT_WIDTH=2, force 5 load-use hazards → bubble_count stops at 3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage signal bundle: decode-side inputs, forwarding writeback, and the
// registered EX-side view. The stage itself takes the slave modport.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  // Pipeline control
  logic                      flush;
  logic                      stall_in;
  logic                      hazard_stall;

  // ID side
  logic                      id_valid;
  logic [31:0]               id_instr;
  logic [31:0]               id_pc_plus4;
  logic [DATA_WIDTH-1:0]     id_rd_data1;
  logic [DATA_WIDTH-1:0]     id_rd_data2;
  logic                      id_reg_write;
  logic                      id_mem_to_reg;
  logic                      id_mem_write;
  logic                      id_mem_read;
  logic                      id_branch;
  logic                      id_alu_src;
  logic                      id_reg_dst;
  logic [1:0]                id_alu_op;

  // Writeback forwarding
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_write_reg;
  logic [DATA_WIDTH-1:0]     wb_data;

  // EX side
  logic                      ex_valid;
  logic [31:0]               ex_pc_plus4;
  logic [DATA_WIDTH-1:0]     ex_rs_data;
  logic [DATA_WIDTH-1:0]     ex_rt_data;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_write_reg;
  logic [4:0]                ex_shamt;
  logic [5:0]                ex_funct;
  logic                      ex_reg_write;
  logic                      ex_mem_to_reg;
  logic                      ex_mem_write;
  logic                      ex_mem_read;
  logic                      ex_branch;
  logic                      ex_alu_src;
  logic [1:0]                ex_alu_op;
  logic [CNT_WIDTH-1:0]      bubble_count;

  // Handshake: there is no valid/ready pair here. id_valid qualifies the ID
  // slot; hazard_stall tells upstream to hold it; stall_in tells this stage to
  // hold; flush squashes. An ID instruction is consumed on a clock edge where
  // rst, flush, stall_in and hazard_stall are all low.
  modport master (
    output flush, stall_in,
    output id_valid, id_instr, id_pc_plus4, id_rd_data1, id_rd_data2,
    output id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read,
    output id_branch, id_alu_src, id_reg_dst, id_alu_op,
    output wb_reg_write, wb_write_reg, wb_data,
    input  hazard_stall,
    input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
    input  ex_rs, ex_rt, ex_write_reg, ex_shamt, ex_funct,
    input  ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
    input  ex_branch, ex_alu_src, ex_alu_op, bubble_count
  );

  modport slave (
    input  flush, stall_in,
    input  id_valid, id_instr, id_pc_plus4, id_rd_data1, id_rd_data2,
    input  id_reg_write, id_mem_to_reg, id_mem_write, id_mem_read,
    input  id_branch, id_alu_src, id_reg_dst, id_alu_op,
    input  wb_reg_write, wb_write_reg, wb_data,
    output hazard_stall,
    output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
    output ex_rs, ex_rt, ex_write_reg, ex_shamt, ex_funct,
    output ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
    output ex_branch, ex_alu_src, ex_alu_op, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core: operand capture with
// writeback bypass, immediate extension, load-use hazard bubbles, stall/flush.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc_plus4;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
    logic [4:0]                shamt;
    logic [5:0]                funct;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      mem_write;
    logic                      mem_read;
    logic                      branch;
    logic                      alu_src;
    logic [1:0]                alu_op;
  } ex_reg_t;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  ex_reg_t              ex_q, ex_d;
  ex_reg_t              id_load;
  logic [CNT_WIDTH-1:0] bubble_count_q, bubble_count_d;

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] id_rs, id_rt, id_rd;
  logic [15:0]               imm16;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic [DATA_WIDTH-1:0]     rs_fwd, rt_fwd;
  logic                      hazard;

  // Instruction field decode and immediate extension
  always_comb begin
    opcode = bus.id_instr[31:26];
    id_rs  = REG_ADDR_WIDTH'(bus.id_instr[25:21]);
    id_rt  = REG_ADDR_WIDTH'(bus.id_instr[20:16]);
    id_rd  = REG_ADDR_WIDTH'(bus.id_instr[15:11]);
    imm16  = bus.id_instr[15:0];
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
      imm_ext = {{(DATA_WIDTH-16){1'b0}}, imm16};
    end else begin
      imm_ext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    end
  end

  // Same-cycle writeback bypass; register 0 is hardwired and never forwarded
  always_comb begin
    rs_fwd = bus.id_rd_data1;
    rt_fwd = bus.id_rd_data2;
    if (bus.wb_reg_write && (bus.wb_write_reg != '0) && (bus.wb_write_reg == id_rs)) begin
      rs_fwd = bus.wb_data;
    end
    if (bus.wb_reg_write && (bus.wb_write_reg != '0) && (bus.wb_write_reg == id_rt)) begin
      rt_fwd = bus.wb_data;
    end
  end

  // Load-use: the load in EX has not produced data yet, so a dependent ID
  // instruction must wait one cycle behind a bubble. Reads ex_q directly so
  // the check stays live while stall_in holds the register.
  always_comb begin
    hazard = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
             ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
    if (bus.flush) begin
      hazard = 1'b0;
    end
  end

  // What the register would take from ID this cycle
  always_comb begin
    id_load           = '0;
    id_load.valid     = bus.id_valid;
    id_load.pc_plus4  = bus.id_pc_plus4;
    id_load.rs_data   = rs_fwd;
    id_load.rt_data   = rt_fwd;
    id_load.imm       = imm_ext;
    id_load.rs        = id_rs;
    id_load.rt        = id_rt;
    id_load.write_reg = bus.id_reg_dst ? id_rd : id_rt;
    id_load.shamt     = bus.id_instr[10:6];
    id_load.funct     = bus.id_instr[5:0];
    if (bus.id_valid) begin
      id_load.reg_write  = bus.id_reg_write;
      id_load.mem_to_reg = bus.id_mem_to_reg;
      id_load.mem_write  = bus.id_mem_write;
      id_load.mem_read   = bus.id_mem_read;
      id_load.branch     = bus.id_branch;
      id_load.alu_src    = bus.id_alu_src;
      id_load.alu_op     = bus.id_alu_op;
    end
  end

  // Update priority: flush > stall_in > hazard bubble > load from ID
  always_comb begin
    ex_d           = ex_q;
    bubble_count_d = bubble_count_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (!bus.stall_in) begin
      if (hazard) begin
        ex_d = '0;
        if (bubble_count_q != '1) begin
          bubble_count_d = bubble_count_q + 1'b1;
        end
      end else begin
        ex_d = id_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc_plus4   = ex_q.pc_plus4;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_write_reg  = ex_q.write_reg;
  assign bus.ex_shamt      = ex_q.shamt;
  assign bus.ex_funct      = ex_q.funct;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage (bubble counter built 2 bits wide so
// saturation is reachable), plus hand sequences for reset corner cases.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  // Control encodings {rw,mtr,mw,mr,br,as,rdst,aop[1:0]}
  localparam logic [8:0] C_ADDI = 9'b100001000;
  localparam logic [8:0] C_LW   = 9'b110101000;
  localparam logic [8:0] C_ADD  = 9'b100000110;
  localparam logic [8:0] C_ORI  = 9'b100001011;
  // Expected registered controls {rw,mtr,mw,mr,br,as,aop[1:0]}
  localparam logic [7:0] E_ADDI = 8'b10000100;
  localparam logic [7:0] E_LW   = 8'b11010100;
  localparam logic [7:0] E_ADD  = 8'b10000010;
  localparam logic [7:0] E_ORI  = 8'b10000111;

  localparam logic [31:0] I_ADDI  = 32'h2108FFFC; // addi $8,$8,-4
  localparam logic [31:0] I_ORI   = 32'h3508FFFC; // ori  $8,$8,0xFFFC
  localparam logic [31:0] I_ADD9  = 32'h012A1820; // add  $3,$9,$10
  localparam logic [31:0] I_LW5   = 32'h8C250004; // lw   $5,4($1)
  localparam logic [31:0] I_ADDRS = 32'h00A23020; // add  $6,$5,$2
  localparam logic [31:0] I_ADDRT = 32'h00453020; // add  $6,$2,$5
  localparam logic [31:0] I_LW0   = 32'h8C200004; // lw   $0,4($1)
  localparam logic [31:0] I_ADD00 = 32'h00003020; // add  $6,$0,$0

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] wr;
    logic [7:0]    ctl;
    logic [CW-1:0] bc;
  } exp_t;

  typedef struct {
    logic          flush;
    logic          stall;
    logic          valid;
    logic [31:0]   instr;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [8:0]    ctl;
    logic          wb_we;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          hz;
    exp_t          e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  id_ex_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ex(logic v, logic [DW-1:0] rsd, logic [DW-1:0] rtd,
                              logic [DW-1:0] imm, logic [AW-1:0] rs, logic [AW-1:0] rt,
                              logic [AW-1:0] wr, logic [7:0] ctl, logic [CW-1:0] bc);
    exp_t e;
    e.valid = v; e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
    e.rs = rs; e.rt = rt; e.wr = wr; e.ctl = ctl; e.bc = bc;
    return e;
  endfunction

  function automatic exp_t bub(logic [CW-1:0] bc);
    return ex(1'b0, '0, '0, '0, '0, '0, '0, 8'h00, bc);
  endfunction

  function automatic vec_t mk(logic fl, logic st, logic vd, logic [31:0] instr,
                              logic [DW-1:0] rd1, logic [DW-1:0] rd2, logic [8:0] ctl,
                              logic wbe, logic [AW-1:0] wbr, logic [DW-1:0] wbd,
                              logic hz, exp_t e);
    vec_t v;
    v.flush = fl; v.stall = st; v.valid = vd; v.instr = instr;
    v.rd1 = rd1; v.rd2 = rd2; v.ctl = ctl;
    v.wb_we = wbe; v.wb_reg = wbr; v.wb_data = wbd; v.hz = hz; v.e = e;
    return v;
  endfunction

  // Driver
  task automatic drive(vec_t v, logic [31:0] pc);
    bus.flush         = v.flush;
    bus.stall_in      = v.stall;
    bus.id_valid      = v.valid;
    bus.id_instr      = v.instr;
    bus.id_pc_plus4   = pc;
    bus.id_rd_data1   = v.rd1;
    bus.id_rd_data2   = v.rd2;
    {bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_write, bus.id_mem_read,
     bus.id_branch, bus.id_alu_src, bus.id_reg_dst, bus.id_alu_op} = v.ctl;
    bus.wb_reg_write  = v.wb_we;
    bus.wb_write_reg  = v.wb_reg;
    bus.wb_data       = v.wb_data;
  endtask

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, req);
    end
  endtask

  // Scoreboard: compare the registered EX view against the oldest expectation
  task automatic compare_ex(int idx);
    exp_t e;
    logic [7:0] ctl;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty [%0d]: got 0 entries, expected 1", idx);
      return;
    end
    e = exp_q.pop_front();
    ctl = {bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_mem_read,
           bus.ex_branch, bus.ex_alu_src, bus.ex_alu_op};
    check("ex_valid",     idx, 64'(bus.ex_valid),     64'(e.valid));
    check("ex_rs_data",   idx, 64'(bus.ex_rs_data),   64'(e.rs_data));
    check("ex_rt_data",   idx, 64'(bus.ex_rt_data),   64'(e.rt_data));
    check("ex_imm",       idx, 64'(bus.ex_imm),       64'(e.imm));
    check("ex_rs",        idx, 64'(bus.ex_rs),        64'(e.rs));
    check("ex_rt",        idx, 64'(bus.ex_rt),        64'(e.rt));
    check("ex_write_reg", idx, 64'(bus.ex_write_reg), 64'(e.wr));
    check("ex_controls",  idx, 64'(ctl),              64'(e.ctl));
    check("bubble_count", idx, 64'(bus.bubble_count), 64'(e.bc));
  endtask

  initial begin
    // Reset with junk on the inputs: a load in ID and a live writeback
    rst = 1'b1;
    drive(mk(1'b0, 1'b0, 1'b1, I_LW5, 32'h1234, 32'h5678, C_LW, 1'b1, 5'd5,
             32'hFFFF_FFFF, 1'b0, bub(2'd0)), 32'h0000_0BAD);
    @(posedge clk); @(posedge clk); #1;
    exp_q.push_back(bub(2'd0));
    compare_ex(-1);
    check("reset_hazard_stall", -1, 64'(bus.hazard_stall), 64'd0);
    check("reset_ex_pc_plus4",  -1, 64'(bus.ex_pc_plus4),  64'd0);
    rst = 1'b0;

    // Stimulus table
    vecs.push_back(mk(0,0,1, I_ADDI, 32'h10, 32'h20, C_ADDI, 0, 0, 0, 0,
                      ex(1, 32'h10, 32'h20, 32'hFFFFFFFC, 8, 8, 8, E_ADDI, 0)));
    vecs.push_back(mk(0,0,1, I_ORI, 32'h11, 32'h22, C_ORI, 0, 0, 0, 0,
                      ex(1, 32'h11, 32'h22, 32'h0000FFFC, 8, 8, 8, E_ORI, 0)));
    vecs.push_back(mk(0,0,1, I_ADD9, 32'h1, 32'h2, C_ADD, 1, 9, 32'hDEADBEEF, 0,
                      ex(1, 32'hDEADBEEF, 32'h2, 32'h1820, 9, 10, 3, E_ADD, 0)));
    vecs.push_back(mk(0,0,1, I_ADD9, 32'h1, 32'h2, C_ADD, 1, 0, 32'hDEADBEEF, 0,
                      ex(1, 32'h1, 32'h2, 32'h1820, 9, 10, 3, E_ADD, 0)));
    vecs.push_back(mk(0,0,1, I_ADD9, 32'h1, 32'h2, C_ADD, 1, 10, 32'hCAFEF00D, 0,
                      ex(1, 32'h1, 32'hCAFEF00D, 32'h1820, 9, 10, 3, E_ADD, 0)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 0)));
    vecs.push_back(mk(0,0,1, I_ADDRS, 32'h33, 32'h44, C_ADD, 0, 0, 0, 1, bub(1)));
    vecs.push_back(mk(0,0,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 0,
                      ex(1, 32'h55, 32'h66, 32'h3020, 5, 2, 6, E_ADD, 1)));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0,1,1, 32'hFFFFFFFF, 32'h9, 32'h9, C_LW, 1, 7, 0, 0,
                        ex(1, 32'h55, 32'h66, 32'h3020, 5, 2, 6, E_ADD, 1)));
    end
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 1)));
    vecs.push_back(mk(1,1,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 0, bub(1)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 1)));
    vecs.push_back(mk(0,1,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 1,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 1)));
    vecs.push_back(mk(0,0,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 1, bub(2)));
    vecs.push_back(mk(0,0,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 0,
                      ex(1, 32'h55, 32'h66, 32'h3020, 5, 2, 6, E_ADD, 2)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 2)));
    vecs.push_back(mk(0,0,1, I_ADDRT, 32'h77, 32'h88, C_ADD, 0, 0, 0, 1, bub(3)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 3)));
    vecs.push_back(mk(0,0,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 1, bub(3)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 3)));
    vecs.push_back(mk(0,0,1, I_ADDRT, 32'h77, 32'h88, C_ADD, 0, 0, 0, 1, bub(3)));
    vecs.push_back(mk(0,0,1, I_LW0, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 0, 0, E_LW, 3)));
    vecs.push_back(mk(0,0,1, I_ADD00, 32'h12, 32'h34, C_ADD, 0, 0, 0, 0,
                      ex(1, 32'h12, 32'h34, 32'h3020, 0, 0, 6, E_ADD, 3)));
    vecs.push_back(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0,
                      ex(1, 32'h100, 32'h7, 32'h4, 1, 5, 5, E_LW, 3)));
    vecs.push_back(mk(0,0,0, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 0,
                      ex(0, 32'h55, 32'h66, 32'h3020, 5, 2, 6, 8'h00, 3)));
    vecs.push_back(mk(0,0,1, I_ADDI, 32'h10, 32'h20, C_ADDI, 0, 0, 0, 0,
                      ex(1, 32'h10, 32'h20, 32'hFFFFFFFC, 8, 8, 8, E_ADDI, 3)));

    // Apply table: hazard_stall checked combinationally, EX view next cycle
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], 32'h400 + 32'(i) * 4);
      #1;
      check("hazard_stall", i, 64'(bus.hazard_stall), 64'(vecs[i].hz));
      exp_q.push_back(vecs[i].e);
      @(posedge clk); #1;
      compare_ex(i);
    end

    // Reset in the middle of a pending load-use hazard
    drive(mk(0,0,1, I_LW5, 32'h100, 32'h7, C_LW, 0, 0, 0, 0, bub(0)), 32'h500);
    @(posedge clk); #1;
    drive(mk(0,0,1, I_ADDRS, 32'h55, 32'h66, C_ADD, 0, 0, 0, 0, bub(0)), 32'h504);
    #1;
    check("pre_reset_hazard_stall", 100, 64'(bus.hazard_stall), 64'd1);
    rst = 1'b1;
    exp_q.push_back(bub(0));
    @(posedge clk); #1;
    rst = 1'b0;
    compare_ex(100);
    check("post_reset_hazard_stall", 100, 64'(bus.hazard_stall), 64'd0);

    // Pass-through of pc, shamt and funct right after reset
    drive(mk(0,0,1, 32'h00A23160, 32'hA, 32'hB, C_ADD, 0, 0, 0, 0, bub(0)), 32'h1234);
    exp_q.push_back(ex(1, 32'hA, 32'hB, 32'h3160, 5, 2, 6, E_ADD, 0));
    @(posedge clk); #1;
    compare_ex(101);
    check("ex_pc_plus4", 101, 64'(bus.ex_pc_plus4), 64'h1234);
    check("ex_shamt",    101, 64'(bus.ex_shamt),    64'd5);
    check("ex_funct",    101, 64'(bus.ex_funct),    64'h20);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
